// File: rtl/dense_argmax_if.sv
// dense_argmax_if: start/done handshake and score-buffer read port shared
// between the layer sequencer (master) and the argmax stage (slave).
interface dense_argmax_if #(
  parameter int ADR_WIDTH = 4,
  parameter int DATA_SIZE = 32
);
  logic                 start;
  logic                 done;
  logic [ADR_WIDTH-1:0] bufferIn_adr;
  logic [DATA_SIZE-1:0] bufferIn_data;

  modport master (
    output start,
    input  done,
    input  bufferIn_adr,
    output bufferIn_data
  );

  modport slave (
    input  start,
    output done,
    output bufferIn_adr,
    input  bufferIn_data
  );
endinterface

// File: rtl/dense_argmax.sv
// dense_argmax: scans the dense-layer score buffer and reports the index of
// the largest signed score as the predicted class.
// Optional feature macro: DENSE_ARGMAX_SCORE_OUT_EN adds the scoreOut port
// carrying the winning score.
module dense_argmax #(
  parameter int CLASS_COUNT = 10,
  parameter int DATA_SIZE   = 32,
  parameter int ADR_WIDTH   = 4,
  parameter int CLASS_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  dense_argmax_if.slave          axisif,
  output logic [CLASS_WIDTH-1:0] classOut,
  output logic                   busy
`ifdef DENSE_ARGMAX_SCORE_OUT_EN
  ,
  output logic [DATA_SIZE-1:0]   scoreOut
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ADR_WIDTH-1:0] LAST_IDX = ADR_WIDTH'(CLASS_COUNT - 1);

  state_t                       r_state;
  state_t                       w_next_state;
  logic [ADR_WIDTH-1:0]         r_cnt;
  logic [ADR_WIDTH-1:0]         r_adr;
  logic signed [DATA_SIZE-1:0]  r_best_val;
  logic [CLASS_WIDTH-1:0]       r_best_idx;
  logic [CLASS_WIDTH-1:0]       r_class;
  logic                         r_done;
  logic                         r_busy;
  logic                         w_take;
  logic                         w_last;
  logic signed [DATA_SIZE-1:0]  w_data;
  logic signed [DATA_SIZE-1:0]  w_cand_val;
  logic [CLASS_WIDTH-1:0]       w_cand_idx;

  assign w_data              = $signed(axisif.bufferIn_data);
  assign axisif.bufferIn_adr = r_adr;
  assign axisif.done         = r_done;
  assign classOut            = r_class;
  assign busy                = r_busy;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode plus the compare that picks the running best score.
  always_comb begin
    w_next_state = r_state;
    w_take       = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        if (axisif.start) begin
          w_next_state = SCAN;
        end else begin
          w_next_state = IDLE;
        end
      end
      SCAN: begin
        // Index 0 always seeds the best value; afterwards only a strictly
        // larger score replaces it, so ties keep the lowest index.
        w_take = (r_cnt == '0) || (w_data > r_best_val);
        if (r_cnt == LAST_IDX) begin
          w_last       = 1'b1;
          w_next_state = DONE;
        end else begin
          w_next_state = SCAN;
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
    if (w_take) begin
      w_cand_val = w_data;
      w_cand_idx = CLASS_WIDTH'(r_cnt);
    end else begin
      w_cand_val = r_best_val;
      w_cand_idx = r_best_idx;
    end
  end

  // Scan counter, buffer address, running best, and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_adr      <= '0;
      r_best_val <= '0;
      r_best_idx <= '0;
      r_class    <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_done <= (w_next_state == DONE);
      r_busy <= (w_next_state != IDLE);
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          // Address keeps its last value while idle and rewinds only when
          // a new scan is accepted.
          if (axisif.start) begin
            r_adr <= '0;
          end
        end
        SCAN: begin
          r_best_val <= w_cand_val;
          r_best_idx <= w_cand_idx;
          if (w_last) begin
            r_class <= w_cand_idx;
          end else begin
            r_cnt <= r_cnt + ADR_WIDTH'(1);
            r_adr <= r_cnt + ADR_WIDTH'(1);
          end
        end
        DONE: begin
          r_cnt <= '0;
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

`ifdef DENSE_ARGMAX_SCORE_OUT_EN
  logic [DATA_SIZE-1:0] r_score;
  assign scoreOut = r_score;

  // Winning score, captured alongside classOut on the edge entering DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_score <= '0;
    end else if ((r_state == SCAN) && w_last) begin
      r_score <= w_cand_val;
    end
  end
`endif

endmodule

// File: doc/dense_argmax.md
# dense_argmax

- Classification stage directly downstream of the dense layer.
- After a dense pass completes, walks the dense output buffer (one signed score per class) and picks the index of the largest score.
- Presents that index as the predicted MNIST digit with a one-cycle completion pulse.
- Uses the same start/done and buffer-address conventions as the other layer blocks, so the top-level sequencer chains it after the dense layer's done pulse.

## Interface
Parameters:
- CLASS_COUNT, 10, number of scores to scan; valid range 2..2^ADR_WIDTH.
- DATA_SIZE, 32, score width; signed two's complement.
- ADR_WIDTH, 4, score buffer address width.
- CLASS_WIDTH, 4, width of the class index output.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- axisif_start  input  1  begin a scan; sampled only in IDLE.
- axisif_done  output  1  one-cycle pulse when the result is valid.
- axisif_bufferIn_adr  output  ADR_WIDTH  read address into the dense output buffer.
- axisif_bufferIn_data  input  DATA_SIZE  score at bufferIn_adr; combinational read, valid in the same cycle.
- classOut  output  CLASS_WIDTH  winning class index; held until the next completion.
- busy  output  1  high in SCAN and DONE.

## Operation
States: IDLE, SCAN, DONE.
- IDLE
  - busy=0; the counter is held at 0.
  - axisif_start=1 -> SCAN.
- SCAN
  - Drive bufferIn_adr = cnt.
  - Compare bufferIn_data against bestVal, signed.
  - When cnt==0, or data > bestVal strictly: bestVal<=data, bestIdx<=cnt.
  - cnt increments each cycle.
  - When cnt==CLASS_COUNT-1: perform the final compare and go to DONE.
- DONE
  - classOut <= final bestIdx (including a last-cycle update).
  - axisif_done=1 for exactly this cycle.
  - -> IDLE; cnt cleared.

Arithmetic and width rules:
- Comparison is a full-width signed compare; no saturation or truncation.
- Ties resolve to the lowest index, because later equal scores do not replace the best.
- bestVal is internal and DATA_SIZE wide; bestIdx is CLASS_WIDTH wide.
- The upper bits of classOut are zero when ADR_WIDTH < CLASS_WIDTH.

Boundary conditions:
- axisif_start while in SCAN or DONE: ignored; no restart and no queuing.
- axisif_start held high continuously: a new scan starts on the first IDLE cycle, giving back-to-back scans every CLASS_COUNT+2 cycles.
- Maximum negative score, e.g. 0x80000000: handled correctly, since index 0 always seeds bestVal.
- Reset asserted mid-scan:
  - Immediately returns to IDLE.
  - Clears cnt, bestVal, bestIdx and classOut.
  - No done pulse is produced.

## Timing
Reset values:
- State = IDLE.
- axisif_done=0, busy=0, classOut=0, axisif_bufferIn_adr=0, bestVal=0, bestIdx=0.

Scan timeline (start sampled high in IDLE at edge k):
- Cycles k+1 .. k+CLASS_COUNT are the SCAN cycles, with addresses 0..CLASS_COUNT-1.
- Cycle k+CLASS_COUNT+1 is DONE: axisif_done is high and classOut is updated on that cycle's entry edge.
- Latency from start to done is CLASS_COUNT+1 cycles (11 with the default).

Other timing rules:
- bufferIn_adr is registered (it equals cnt) and holds its last value outside SCAN.
- classOut changes only on the edge entering DONE.

## Configuration
- DENSE_ARGMAX_SCORE_OUT_EN
  - Defined: adds output port scoreOut [DATA_SIZE-1:0], which carries the winning score. It updates together with classOut, resets to 0, and holds between scans.
  - Undefined: the port does not exist, and no logic or registers for it are built. All other behaviour is identical.

## Test plan
- Scores 0..9 = {5,-3,7,2,100,0,-50,99,1,4}, pulse start -> done high exactly 11 cycles after the start edge; classOut=4; addresses 0..9 observed in consecutive cycles.
- Tie: scores {1,9,3,9,0,0,0,0,0,9} -> classOut=1 (lowest index wins).
- All negative, index 9 = 0x80000001, all others = 0x80000000 -> classOut=9. Repeat with all scores equal to 0x80000000 -> classOut=0.
- Start held high for 30 cycles, with different buffer contents loaded before each scan -> done pulses every 12 cycles; each classOut matches its own scan; extra starts during SCAN are ignored.
- Reset low at the 5th SCAN cycle -> busy=0, classOut=0, adr=0 immediately; no done pulse. A subsequent start runs a normal 11-cycle scan.
- With DENSE_ARGMAX_SCORE_OUT_EN defined, first scenario -> scoreOut=100. With the macro undefined, the build has no scoreOut port.
